// File: rtl/rrf_pkg.sv
// Shared sizes and types for the retirement register file and its free list.
package rrf_pkg;
    localparam int unsigned NUM_ARCH_REGS   = 32;
    localparam int unsigned NUM_PHYS_REGS   = 64;
    localparam int unsigned FREE_LIST_DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS;
    localparam int unsigned IDX_W           = 5;
    localparam int unsigned PTR_W           = IDX_W + 1;

    typedef logic [5:0]       phys_reg_t;
    typedef logic [4:0]       arch_reg_t;
    typedef logic [PTR_W-1:0] fl_ptr_t;
endpackage

// File: rtl/rrf_free_list.sv
// Circular physical-register free list: push at tail, speculative pop at
// spec_head, committed pop at commit_head, and rollback of spec_head on flush.
module rrf_free_list
    import rrf_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  phys_reg_t push_pd,
    input  logic      commit_pop,
    input  logic      alloc_req,
    input  logic      flush,
    output phys_reg_t alloc_pd,
    output logic      alloc_valid,
    output fl_ptr_t   free_count
);
    phys_reg_t fl [FREE_LIST_DEPTH];
    fl_ptr_t   tail;
    fl_ptr_t   spec_head;
    fl_ptr_t   commit_head;
    fl_ptr_t   commit_head_nxt;
    logic      fire;

    assign free_count      = tail - spec_head;
    assign alloc_valid     = (free_count != '0);
    assign alloc_pd        = fl[spec_head[IDX_W-1:0]];
    assign fire            = alloc_req && alloc_valid && !flush;
    assign commit_head_nxt = commit_head + fl_ptr_t'(commit_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < FREE_LIST_DEPTH; k++) begin
                fl[k] <= phys_reg_t'(NUM_ARCH_REGS + k);
            end
            tail        <= fl_ptr_t'(FREE_LIST_DEPTH);
            spec_head   <= '0;
            commit_head <= '0;
        end else begin
            if (push) begin
                fl[tail[IDX_W-1:0]] <= push_pd;
                tail                <= tail + fl_ptr_t'(1);
            end
            commit_head <= commit_head_nxt;
            // Rollback targets the post-retire commit point so a coincident retire is kept.
            if (flush) begin
                spec_head <= commit_head_nxt;
            end else if (fire) begin
                spec_head <= spec_head + fl_ptr_t'(1);
            end
        end
    end
endmodule

// File: rtl/rrf.sv
// Retirement register file: committed arch->phys map plus the free list that
// recycles displaced physical registers back to rename.
module rrf
    import rrf_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      commit_valid,
    input  arch_reg_t commit_rd,
    input  phys_reg_t commit_pd,
    input  logic      commit_regf_we,
    input  logic      alloc_req,
    output phys_reg_t alloc_pd,
    output logic      alloc_valid,
    input  logic      flush,
    output phys_reg_t rrf_map [NUM_ARCH_REGS],
    output fl_ptr_t   free_count
);
    phys_reg_t map [NUM_ARCH_REGS];
    logic      retire;
    phys_reg_t old_pd;

    // x0 never retires, so map[0] stays p0 and p0 is never freed.
    assign retire = commit_valid && commit_regf_we && (commit_rd != '0);
    assign old_pd = map[commit_rd];
    assign rrf_map = map;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_ARCH_REGS; i++) begin
                map[i] <= phys_reg_t'(i);
            end
        end else if (retire) begin
            map[commit_rd] <= commit_pd;
        end
    end

    rrf_free_list u_free_list (
        .clk        (clk),
        .rst        (rst),
        .push       (retire),
        .push_pd    (old_pd),
        .commit_pop (retire),
        .alloc_req  (alloc_req),
        .flush      (flush),
        .alloc_pd   (alloc_pd),
        .alloc_valid(alloc_valid),
        .free_count (free_count)
    );
endmodule

// File: tb/tb_rrf.sv
// Scoreboard bench for rrf: directed stimulus queues expected values per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_rrf;
    import rrf_pkg::*;

    logic      clk = 1'b0;
    logic      rst = 1'b1;
    logic      commit_valid = 1'b0;
    arch_reg_t commit_rd = '0;
    phys_reg_t commit_pd = '0;
    logic      commit_regf_we = 1'b0;
    logic      alloc_req = 1'b0;
    logic      flush = 1'b0;
    phys_reg_t alloc_pd;
    logic      alloc_valid;
    phys_reg_t rrf_map [NUM_ARCH_REGS];
    fl_ptr_t   free_count;

    rrf dut (
        .clk           (clk),
        .rst           (rst),
        .commit_valid  (commit_valid),
        .commit_rd     (commit_rd),
        .commit_pd     (commit_pd),
        .commit_regf_we(commit_regf_we),
        .alloc_req     (alloc_req),
        .alloc_pd      (alloc_pd),
        .alloc_valid   (alloc_valid),
        .flush         (flush),
        .rrf_map       (rrf_map),
        .free_count    (free_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int test;
        int kind;
        int idx;
        int val;
    } exp_t;

    localparam int K_PD = 0, K_VALID = 1, K_COUNT = 2, K_MAP = 3;

    exp_t q[$];
    int   cnt = 0;
    int   checks = 0;
    int   errors = 0;
    int   test_id = 0;

    always @(posedge clk) cnt <= cnt + 1;

    function automatic string kname(input int k);
        case (k)
            K_PD:    return "alloc_pd";
            K_VALID: return "alloc_valid";
            K_COUNT: return "free_count";
            default: return "rrf_map";
        endcase
    endfunction

    function automatic int actual(input int k, input int idx);
        case (k)
            K_PD:    return int'(alloc_pd);
            K_VALID: return int'(alloc_valid);
            K_COUNT: return int'(free_count);
            default: return int'(rrf_map[idx]);
        endcase
    endfunction

    // Monitor: compares every expectation scheduled for the current cycle.
    always @(negedge clk) begin
        exp_t e;
        int   a;
        while (q.size() > 0 && q[0].cyc <= cnt) begin
            e = q.pop_front();
            a = actual(e.kind, e.idx);
            checks++;
            if (e.cyc != cnt) begin
                errors++;
                $display("FAIL t%0d %s[%0d]: check missed its cycle (sched %0d, now %0d)",
                         e.test, kname(e.kind), e.idx, e.cyc, cnt);
            end else if (a != e.val) begin
                errors++;
                $display("FAIL t%0d %s[%0d]: got %0d expected %0d",
                         e.test, kname(e.kind), e.idx, a, e.val);
            end
        end
        if (!rst) begin
            fl_ptr_t occ;
            occ = dut.u_free_list.tail - dut.u_free_list.commit_head;
            if (occ > 6'd32) begin
                checks++;
                errors++;
                $display("FAIL inv_occupancy: tail-commit_head=%0d limit 32", occ);
            end
            if (free_count > 6'd32) begin
                checks++;
                errors++;
                $display("FAIL inv_free_count: got %0d limit 32", free_count);
            end
        end
    end

    task automatic expect_now(input int k, input int idx, input int v);
        exp_t e;
        e.cyc  = cnt;
        e.test = test_id;
        e.kind = k;
        e.idx  = idx;
        e.val  = v;
        q.push_back(e);
    endtask

    // One clock: apply inputs, pass the edge, return inputs to idle.
    task automatic step(input logic a, input logic cv, input int rd, input int pd,
                        input logic we, input logic fl, input logic r);
        alloc_req      = a;
        commit_valid   = cv;
        commit_rd      = arch_reg_t'(rd);
        commit_pd      = phys_reg_t'(pd);
        commit_regf_we = we;
        flush          = fl;
        rst            = r;
        @(posedge clk);
        #1;
        alloc_req      = 1'b0;
        commit_valid   = 1'b0;
        commit_rd      = '0;
        commit_pd      = '0;
        commit_regf_we = 1'b0;
        flush          = 1'b0;
        rst            = 1'b0;
    endtask

    task automatic idle();             step(0, 0, 0, 0, 0, 0, 0); endtask
    task automatic do_reset();         step(0, 0, 0, 0, 0, 0, 1); endtask
    task automatic alloc();            step(1, 0, 0, 0, 0, 0, 0); endtask
    task automatic retire(input int rd, input int pd); step(0, 1, rd, pd, 1, 0, 0); endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        do_reset();

        // t1: reset state
        test_id = 1;
        idle();
        expect_now(K_PD, 0, 32);
        expect_now(K_VALID, 0, 1);
        expect_now(K_COUNT, 0, 32);
        expect_now(K_MAP, 5, 5);
        expect_now(K_MAP, 0, 0);
        expect_now(K_MAP, 31, 31);

        // t2: allocate p32, retire rd5->p32, p5 reappears after wrapping
        test_id = 2;
        alloc();
        expect_now(K_PD, 0, 33);
        expect_now(K_COUNT, 0, 31);
        retire(5, 32);
        expect_now(K_MAP, 5, 32);
        expect_now(K_COUNT, 0, 32);
        for (int i = 0; i < 31; i++) alloc();
        expect_now(K_PD, 0, 5);
        expect_now(K_COUNT, 0, 1);

        // t3: three allocations, one retire, then flush
        test_id = 3;
        do_reset();
        alloc(); alloc(); alloc();
        expect_now(K_PD, 0, 35);
        expect_now(K_COUNT, 0, 29);
        retire(1, 32);
        expect_now(K_MAP, 1, 32);
        expect_now(K_COUNT, 0, 30);
        step(0, 0, 0, 0, 0, 1, 0);
        expect_now(K_PD, 0, 33);
        expect_now(K_COUNT, 0, 32);

        // t4: drain, ignored alloc when empty, retire refills next cycle
        test_id = 4;
        do_reset();
        for (int i = 0; i < 32; i++) alloc();
        expect_now(K_VALID, 0, 0);
        expect_now(K_COUNT, 0, 0);
        alloc();
        expect_now(K_VALID, 0, 0);
        expect_now(K_COUNT, 0, 0);
        expect_now(K_PD, 0, 32);
        retire(7, 40);
        expect_now(K_VALID, 0, 1);
        expect_now(K_PD, 0, 7);
        expect_now(K_COUNT, 0, 1);
        expect_now(K_MAP, 7, 40);

        // t5: retires that must not change state
        test_id = 5;
        do_reset();
        retire(0, 40);
        expect_now(K_MAP, 0, 0);
        expect_now(K_COUNT, 0, 32);
        alloc();
        expect_now(K_COUNT, 0, 31);
        step(0, 1, 3, 41, 0, 0, 0);
        expect_now(K_MAP, 3, 3);
        expect_now(K_COUNT, 0, 31);
        step(0, 0, 3, 42, 1, 0, 0);
        expect_now(K_MAP, 3, 3);
        expect_now(K_COUNT, 0, 31);
        step(0, 0, 0, 0, 0, 1, 0);
        expect_now(K_COUNT, 0, 32);
        expect_now(K_PD, 0, 32);

        // t6: flush + retire + alloc in one cycle
        test_id = 6;
        do_reset();
        alloc(); alloc();
        expect_now(K_PD, 0, 34);
        step(1, 1, 9, 32, 1, 1, 0);
        expect_now(K_MAP, 9, 32);
        expect_now(K_PD, 0, 33);
        expect_now(K_COUNT, 0, 32);

        // t7: alloc + retire in one cycle leave free_count unchanged
        test_id = 7;
        do_reset();
        alloc();
        expect_now(K_COUNT, 0, 31);
        step(1, 1, 2, 32, 1, 0, 0);
        expect_now(K_COUNT, 0, 31);
        expect_now(K_PD, 0, 34);
        expect_now(K_MAP, 2, 32);

        // t8: reset overrides flush, retire and alloc
        test_id = 8;
        step(1, 1, 4, 33, 1, 1, 1);
        expect_now(K_COUNT, 0, 32);
        expect_now(K_PD, 0, 32);
        expect_now(K_MAP, 2, 2);
        expect_now(K_MAP, 4, 4);

        idle();
        idle();
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rrf.md
# rrf

Retirement register file and physical-register free list for the out-of-order core, directly downstream of the ROB. Each cycle it consumes at most one retired ROB entry, records the committed arch→phys mapping, and returns the displaced physical register to a circular free list. The same free list supplies new destination registers to rename/dispatch. On a branch flush it rolls speculative allocations back to the committed point and exposes the committed map for RAT recovery.

## Interface
- NUM_ARCH, 32: architectural registers.
- NUM_PHYS, 64: physical registers; free-list depth = NUM_PHYS − NUM_ARCH = 32.
- clk  in  1  clock; all state changes on posedge clk.
- rst  in  1  synchronous, active-high reset.
- commit_valid  in  1  ROB dequeue_valid; one entry retires this cycle.
- commit_rd  in  5  retiring instruction's architectural rd.
- commit_pd  in  6  physical register allocated to that rd.
- commit_regf_we  in  1  retiring instruction writes rd.
- alloc_req  in  1  rename requests one free physical register. Asserted only for instructions with rd≠0 and regf_we.
- alloc_pd  out  6  physical register at the speculative head.
- alloc_valid  out  1  free list non-empty; allocation fires on alloc_req && alloc_valid && !flush.
- flush  in  1  global_branch_signal; discards all speculative allocations.
- rrf_map  out  32×6  committed map, arch i → phys (unpacked array).
- free_count  out  6  speculative free entries, 0..32.

## Operation
- Storage:
  - map[32] of 6 bits.
  - fl[32] of 6 bits.
  - 6-bit pointers (5 index + wrap): tail, spec_head, commit_head.
- Reset:
  - map[i]=i.
  - fl[k]=32+k.
  - spec_head=commit_head=0; tail=6'b100000 (full).
  - Outputs after reset: alloc_pd=32, alloc_valid=1, free_count=32, rrf_map[i]=i.
- Allocate: on fire, spec_head ← spec_head+1. alloc_pd = fl[spec_head[4:0]].
- Retire: when commit_valid && commit_regf_we && commit_rd≠0:
  - Capture old = map[commit_rd].
  - map[commit_rd] ← commit_pd.
  - fl[tail[4:0]] ← old; tail ← tail+1.
  - commit_head ← commit_head+1.
  - Otherwise (rd=0, !we, or !commit_valid): no state change.
- x0: map[0] stays 0 forever; p0 never enters the free list.
- Flush:
  - spec_head ← next value of commit_head, including a same-cycle retire.
  - An alloc_req in the flush cycle is ignored.
  - Retire in the flush cycle still completes normally.
- Counts: free_count = tail − spec_head, 6-bit modular. alloc_valid = (free_count≠0).
- Invariants:
  - free_count ≤ 32.
  - A push never overflows, because a pushed register was previously popped.
  - A bench assertion flags tail−commit_head > 32.
- Wrap-around: all pointers increment modulo 64; the index is bits [4:0].

## Timing
- alloc_pd and alloc_valid are combinational from registered state only. There is no bypass from a same-cycle push.
  - When empty, a retiring register becomes allocatable the next cycle.
- Allocate + retire in the same cycle: both take effect. free_count is unchanged net.
- rrf_map is registered. A commit's update is visible the cycle after the commit.
  - The RAT copies rrf_map in the cycle after flush, so a retire coincident with the flush is included.
- Retire latency: 1 cycle (map, tail, commit_head).
- Flush latency: 1 cycle; alloc_valid and free_count reflect the rollback the next cycle.
- rst asserted mid-operation restores full reset state at the next edge; it overrides flush, commit and alloc.

## Structure
- rv32i_types additions: localparams NUM_ARCH_REGS=32, NUM_PHYS_REGS=64, FREE_LIST_DEPTH=32; typedef phys_reg_t = logic [5:0].
- Sub-module free_list: circular buffer with push (tail), speculative pop (spec_head), commit pop (commit_head), flush restore and count.
- Top rrf: holds map[] and retire decode, and instantiates free_list.

## Test plan
- Reset then idle: alloc_pd=32, alloc_valid=1, free_count=32, rrf_map[5]=5.
- Allocate p32, then retire rd=5 with pd=32 and we=1:
  - Next cycle rrf_map[5]=32, free_count=32.
  - fl entry at index 0 now holds p5; after 31 further allocations, alloc_pd=5.
- Allocate 3 (p32, p33, p34), retire one (rd=1, pd=32), then flush:
  - Next cycle spec_head=commit_head=1, alloc_pd=33, free_count=32.
- Drain: 32 allocations with no retire → alloc_valid=0, free_count=0.
  - An alloc_req is then ignored.
  - A retire of rd=7 makes alloc_valid=1 the following cycle, with alloc_pd=7.
- Retire with commit_rd=0 or commit_regf_we=0 → map, tail and commit_head unchanged.
- Flush + retire + alloc_req in the same cycle:
  - The retire lands.
  - The alloc is dropped.
  - spec_head equals the post-retire commit_head.
